apb_master: RTL and testbench

APB initiator bridging the RISC-V core's simple load/store bus to the peripheral APB bus. It latches one CPU request and runs the APB SETUP and ACCESS phases. It decodes the address into one of five peripheral selects (RAM, GPO, GPI, GPIO, UART) and multiplexes the selected slave's PRDATA/PREADY back to the core. A bounded wait timeout converts a hung slave into an error completion.

---
 rtl/apb_master.sv | 173 +++++++++++++++++
 tb/tb_apb_master.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//   APB initiator between the core's load/store strobe bus and five APB
//   peripherals (RAM, GPO, GPI, GPIO, UART). It latches one request in IDLE,
//   runs SETUP then ACCESS, and returns a single-cycle o_ready pulse. An
//   unmapped address or a slave that never raises PREADY ends the transfer
//   with o_err=1.
//
// Ports
//   PCLK, PRESET          clock, asynchronous active-high reset
//   i_transfer            request strobe, sampled only in IDLE
//   i_write               1 = write, 0 = read
//   i_addr, i_wdata       byte address and write data
//   o_rdata               read data, nonzero only in a successful read completion
//   o_ready, o_err        completion pulse and its error qualifier
//   PADDR/PWRITE/PWDATA   APB request, held from latch until the next latch
//   PENABLE               APB access phase
//   PSEL0..4              slave selects: RAM, GPO, GPI, GPIO, UART
//   PRDATA0..4, PREADY0..4 slave responses
//
// Parameter
//   TIMEOUT               ACCESS cycles waited for PREADY (2..255)
// -----------------------------------------------------------------------------
module apb_master #(
   parameter int TIMEOUT = 16
) (
   input  logic        PCLK,
   input  logic        PRESET,
   input  logic        i_transfer,
   input  logic        i_write,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   output logic [31:0] o_rdata,
   output logic        o_ready,
   output logic        o_err,
   output logic [31:0] PADDR,
   output logic        PWRITE,
   output logic        PENABLE,
   output logic [31:0] PWDATA,
   output logic        PSEL0,
   output logic        PSEL1,
   output logic        PSEL2,
   output logic        PSEL3,
   output logic        PSEL4,
   input  logic [31:0] PRDATA0,
   input  logic [31:0] PRDATA1,
   input  logic [31:0] PRDATA2,
   input  logic [31:0] PRDATA3,
   input  logic [31:0] PRDATA4,
   input  logic        PREADY0,
   input  logic        PREADY1,
   input  logic        PREADY2,
   input  logic        PREADY3,
   input  logic        PREADY4
);

   localparam int NSLV = 5;
   localparam int CW   = 8;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [31:0]        paddr_q, paddr_d;
   logic [31:0]        pwdata_q, pwdata_d;
   logic               pwrite_q, pwrite_d;
   logic [NSLV-1:0]    sel_q, sel_d;
   logic               unmap_q, unmap_d;

   logic [NSLV-1:0]         pready_v;
   logic [NSLV-1:0][31:0]   prdata_v;
   logic [NSLV-1:0]         dec_sel;
   logic                    sel_ready;
   logic [31:0]             sel_rdata;
   logic                    in_access;
   logic                    timeout;
   logic                    done;
   logic                    err;

   assign pready_v = {PREADY4, PREADY3, PREADY2, PREADY1, PREADY0};
   assign prdata_v = {PRDATA4, PRDATA3, PRDATA2, PRDATA1, PRDATA0};

   // Peripheral page 0x1000_xxxx, slave number in bits [15:12].
   always_comb begin
      dec_sel = '0;
      for (int s = 0; s < NSLV; s++)
         dec_sel[s] = (i_addr[31:16] == 16'h1000) && (i_addr[15:12] == 4'(s));
   end

   // sel_q is one-hot or zero, so an AND-OR mux is enough and only the
   // selected slave can contribute ready/data.
   always_comb begin
      sel_rdata = '0;
      for (int s = 0; s < NSLV; s++)
         sel_rdata = sel_rdata | (prdata_v[s] & {32{sel_q[s]}});
   end
   assign sel_ready = |(sel_q & pready_v);

   assign in_access = (state_q == ACCESS);
   assign timeout   = (cnt_q == CW'(TIMEOUT - 1));
   // A PREADY in the timeout cycle still counts as a normal completion.
   assign done      = in_access && (unmap_q || sel_ready || timeout);
   assign err       = in_access && (unmap_q || (!sel_ready && timeout));

   assign o_ready = done;
   assign o_err   = err;
   assign o_rdata = (done && !err && !pwrite_q) ? sel_rdata : 32'h0;

   assign PADDR   = paddr_q;
   assign PWDATA  = pwdata_q;
   assign PWRITE  = pwrite_q;
   assign PENABLE = in_access;
   // sel_q keeps the last decode after completion; gate it with the state.
   assign PSEL0   = sel_q[0] && (state_q != IDLE);
   assign PSEL1   = sel_q[1] && (state_q != IDLE);
   assign PSEL2   = sel_q[2] && (state_q != IDLE);
   assign PSEL3   = sel_q[3] && (state_q != IDLE);
   assign PSEL4   = sel_q[4] && (state_q != IDLE);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      paddr_d  = paddr_q;
      pwdata_d = pwdata_q;
      pwrite_d = pwrite_q;
      sel_d    = sel_q;
      unmap_d  = unmap_q;
      unique case (state_q)
         IDLE: begin
            if (i_transfer) begin
               paddr_d  = i_addr;
               pwdata_d = i_wdata;
               pwrite_d = i_write;
               sel_d    = dec_sel;
               unmap_d  = ~|dec_sel;
               state_d  = SETUP;
            end
         end
         SETUP: begin
            cnt_d   = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (done)
               state_d = IDLE;
            else if (cnt_q != '1)
               cnt_d = cnt_q + 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or posedge PRESET) begin
      if (PRESET) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         paddr_q  <= '0;
         pwdata_q <= '0;
         pwrite_q <= 1'b0;
         sel_q    <= '0;
         unmap_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         paddr_q  <= paddr_d;
         pwdata_q <= pwdata_d;
         pwrite_q <= pwrite_d;
         sel_q    <= sel_d;
         unmap_q  <= unmap_d;
      end
   end

endmodule

// File: tb/tb_apb_master.sv
module tb_apb_master;

   logic        PCLK = 1'b0;
   logic        PRESET;
   logic        i_transfer, i_write;
   logic [31:0] i_addr, i_wdata;
   logic [31:0] o_rdata;
   logic        o_ready, o_err;
   logic [31:0] PADDR, PWDATA;
   logic        PWRITE, PENABLE;
   logic        PSEL0, PSEL1, PSEL2, PSEL3, PSEL4;
   logic [31:0] PRDATA0, PRDATA1, PRDATA2, PRDATA3, PRDATA4;
   logic        PREADY0, PREADY1, PREADY2, PREADY3, PREADY4;

   always #5 PCLK = ~PCLK;

   apb_master #(.TIMEOUT(16)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .i_transfer(i_transfer), .i_write(i_write), .i_addr(i_addr), .i_wdata(i_wdata),
      .o_rdata(o_rdata), .o_ready(o_ready), .o_err(o_err),
      .PADDR(PADDR), .PWRITE(PWRITE), .PENABLE(PENABLE), .PWDATA(PWDATA),
      .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2), .PSEL3(PSEL3), .PSEL4(PSEL4),
      .PRDATA0(PRDATA0), .PRDATA1(PRDATA1), .PRDATA2(PRDATA2), .PRDATA3(PRDATA3), .PRDATA4(PRDATA4),
      .PREADY0(PREADY0), .PREADY1(PREADY1), .PREADY2(PREADY2), .PREADY3(PREADY3), .PREADY4(PREADY4)
   );

   // Slave models: slave s raises PREADY in ACCESS cycle index ws[s].
   int          ws [5];
   int          acc;
   logic        force0;
   logic [4:0]  psel_v;
   logic [4:0]  prdy_v;

   assign psel_v  = {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0};
   assign PRDATA0 = 32'hCAFE_0000;
   assign PRDATA1 = 32'h1111_0001;
   assign PRDATA2 = 32'h0000_00A5;
   assign PRDATA3 = 32'h3333_0003;
   assign PRDATA4 = 32'hDEAD_0004;

   always_comb begin
      prdy_v = '0;
      for (int s = 0; s < 5; s++)
         prdy_v[s] = psel_v[s] && PENABLE && (acc == ws[s]);
      prdy_v[0] = prdy_v[0] | force0;
   end
   assign {PREADY4, PREADY3, PREADY2, PREADY1, PREADY0} = prdy_v;

   always @(posedge PCLK or posedge PRESET)
      if (PRESET || !PENABLE) acc <= 0;
      else                    acc <= acc + 1;

   int cyc = 0;
   always @(posedge PCLK) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Scoreboard: expected completion cycle, read data and error flag.
   typedef struct {
      int          c;
      logic [31:0] rd;
      logic        er;
   } exp_t;
   exp_t sb[$];
   exp_t e;

   always @(negedge PCLK) begin
      if (!PRESET) begin
         if (o_ready) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_ready: o_ready=1 at cycle %0d, expected no completion", cyc);
            end else begin
               e = sb.pop_front();
               chk("rsp_cycle", 32'(cyc), 32'(e.c));
               chk("rsp_rdata", o_rdata, e.rd);
               chk("rsp_err", {31'h0, o_err}, {31'h0, e.er});
            end
         end else begin
            chk("idle_rdata", o_rdata, 32'h0);
         end
      end
   end

   task automatic step();
      @(posedge PCLK);
      #1;
   endtask

   // Present a request in the current cycle N and queue its expected response.
   task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input int lat, input logic [31:0] rd, input logic er, output int n);
      step();
      n = cyc;
      i_transfer = 1'b1;
      i_write    = w;
      i_addr     = a;
      i_wdata    = d;
      sb.push_back('{n + lat, rd, er});
   endtask

   task automatic drain();
      for (int k = 0; k < 40 && sb.size() != 0; k++) step();
      if (sb.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d responses outstanding, expected 0", sb.size());
         sb.delete();
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   int n;

   initial begin
      PRESET = 1'b1;
      i_transfer = 0; i_write = 0; i_addr = 0; i_wdata = 0; force0 = 0;
      for (int s = 0; s < 5; s++) ws[s] = 0;
      step();
      step();
      chk("rst_psel", {27'h0, psel_v}, 32'h0);
      chk("rst_penable", {31'h0, PENABLE}, 32'h0);
      chk("rst_pwrite", {31'h0, PWRITE}, 32'h0);
      chk("rst_paddr", PADDR, 32'h0);
      chk("rst_pwdata", PWDATA, 32'h0);
      chk("rst_ready", {30'h0, o_ready, o_err}, 32'h0);
      chk("rst_rdata", o_rdata, 32'h0);
      PRESET = 1'b0;

      // UART write, slave ready one cycle into ACCESS; rdata forced to 0.
      ws[4] = 1;
      issue(1'b1, 32'h1000_4000, 32'h0000_0041, 3, 32'h0, 1'b0, n);
      step(); i_transfer = 0;                       // N+1 SETUP
      chk("uart_setup_psel", {27'h0, psel_v}, 32'h10);
      chk("uart_setup_penable", {31'h0, PENABLE}, 32'h0);
      chk("uart_pwdata1", PWDATA, 32'h41);
      chk("uart_pwrite", {31'h0, PWRITE}, 32'h1);
      chk("uart_paddr", PADDR, 32'h1000_4000);
      step();                                       // N+2 ACCESS
      chk("uart_access_psel", {27'h0, psel_v}, 32'h10);
      chk("uart_access_penable", {31'h0, PENABLE}, 32'h1);
      chk("uart_pwdata2", PWDATA, 32'h41);
      step();                                       // N+3 completion
      chk("uart_pwdata3", PWDATA, 32'h41);
      step();                                       // N+4 IDLE
      chk("uart_idle_psel", {27'h0, psel_v}, 32'h0);
      chk("uart_idle_penable", {31'h0, PENABLE}, 32'h0);
      chk("uart_pwdata_hold", PWDATA, 32'h41);
      drain();

      // GPI read.
      ws[2] = 1;
      issue(1'b0, 32'h1000_2000, 32'h0, 3, 32'h0000_00A5, 1'b0, n);
      step(); i_transfer = 0;
      chk("gpi_psel_n1", {27'h0, psel_v}, 32'h04);
      step();
      chk("gpi_psel_n2", {27'h0, psel_v}, 32'h04);
      chk("gpi_rdata_n2", o_rdata, 32'h0);
      step();
      chk("gpi_psel_n3", {27'h0, psel_v}, 32'h04);
      step();
      chk("gpi_rdata_n4", o_rdata, 32'h0);
      drain();

      // Unmapped addresses: wrong page and slave number 5.
      issue(1'b0, 32'h2000_0000, 32'h0, 2, 32'h0, 1'b1, n);
      step(); i_transfer = 0;
      chk("unmap_psel_n1", {27'h0, psel_v}, 32'h0);
      step();
      chk("unmap_psel_n2", {27'h0, psel_v}, 32'h0);
      drain();
      issue(1'b1, 32'h1000_5000, 32'h1234_5678, 2, 32'h0, 1'b1, n);
      step(); i_transfer = 0;
      chk("unmap5_psel", {27'h0, psel_v}, 32'h0);
      drain();

      // GPIO timeout with PREADY held low.
      ws[3] = 1000;
      issue(1'b0, 32'h1000_3004, 32'h0, 17, 32'h0, 1'b1, n);
      step(); i_transfer = 0;
      drain();
      chk("tmo_idle_psel", {27'h0, psel_v}, 32'h0);
      chk("tmo_idle_penable", {31'h0, PENABLE}, 32'h0);

      // PREADY arriving in the timeout cycle wins.
      ws[3] = 15;
      issue(1'b0, 32'h1000_3004, 32'h0, 17, 32'h3333_0003, 1'b0, n);
      step(); i_transfer = 0;
      drain();

      // Back-to-back with i_transfer held: completion cycle ignores it.
      ws[1] = 1;
      issue(1'b0, 32'h1000_1000, 32'h0, 3, 32'h1111_0001, 1'b0, n);
      sb.push_back('{n + 7, 32'h1111_0001, 1'b0});
      step();
      chk("b2b_setup1_penable", {31'h0, PENABLE}, 32'h0);
      step();
      chk("b2b_access_penable", {31'h0, PENABLE}, 32'h1);
      step();
      chk("b2b_done_penable", {31'h0, PENABLE}, 32'h1);
      step();
      chk("b2b_idle_psel", {27'h0, psel_v}, 32'h0);
      step(); i_transfer = 0;
      chk("b2b_setup2_psel", {27'h0, psel_v}, 32'h02);
      chk("b2b_setup2_penable", {31'h0, PENABLE}, 32'h0);
      drain();

      // Misdirected PREADY0 while GPO is selected.
      ws[1] = 3;
      issue(1'b0, 32'h1000_1008, 32'h0, 5, 32'h1111_0001, 1'b0, n);
      step(); i_transfer = 0;
      step(); force0 = 1'b1;
      chk("misdir_psel", {27'h0, psel_v}, 32'h02);
      step(); force0 = 1'b0;
      drain();

      // Reset during ACCESS of a write: no completion, outputs drop at once.
      ws[0] = 5;
      step();
      i_transfer = 1; i_write = 1; i_addr = 32'h1000_0010; i_wdata = 32'h77;
      step(); i_transfer = 0;
      step();
      chk("prerst_penable", {31'h0, PENABLE}, 32'h1);
      #1 PRESET = 1'b1;
      #1;
      chk("rst_mid_psel", {27'h0, psel_v}, 32'h0);
      chk("rst_mid_penable", {31'h0, PENABLE}, 32'h0);
      chk("rst_mid_pwrite", {31'h0, PWRITE}, 32'h0);
      chk("rst_mid_ready", {31'h0, o_ready}, 32'h0);
      step();
      step();
      PRESET = 1'b0;
      ws[0] = 0;
      issue(1'b0, 32'h1000_0020, 32'h0, 2, 32'hCAFE_0000, 1'b0, n);
      step(); i_transfer = 0;
      chk("post_rst_psel", {27'h0, psel_v}, 32'h01);
      drain();
      step();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
